mem_arbiter: RTL

//  Arbitrates the pipeline's instruction bus (imem_*) and data bus (dmem_*) onto one

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_lane_gen.sv | 39 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg                                                             |
// | Shared width codes, FSM state type and default timeout for mem_arbiter.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

    localparam logic [1:0] W_BYTE  = 2'd0;
    localparam logic [1:0] W_HALF  = 2'd1;
    localparam logic [1:0] W_WORD  = 2'd2;
    localparam logic [1:0] W_DWORD = 2'd3;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IBUS = 2'd1,
        S_DBUS = 2'd2,
        S_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lane_gen                                                                |
// | Byte-enable and replicated write-data generation for one store.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_lane_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_data,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata
);

    // Offsets are aligned down to the access width before shifting.
    always_comb begin
        o_be    = 8'hFF;
        o_wdata = i_data;
        case (i_width)
            W_BYTE: begin
                o_be    = 8'h01 << i_offset;
                o_wdata = {8{i_data[7:0]}};
            end
            W_HALF: begin
                o_be    = 8'h03 << {i_offset[2:1], 1'b0};
                o_wdata = {4{i_data[15:0]}};
            end
            W_WORD: begin
                o_be    = 8'h0F << {i_offset[2], 2'b00};
                o_wdata = {2{i_data[31:0]}};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                 |
// | Arbitrates fetch and load/store buses onto one single-outstanding port.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter bit IFETCH_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] imem_addr,
    input  logic        imem_addr_valid,
    output logic [63:0] imem_data,
    output logic        imem_data_valid,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic [63:0] dmem_din,
    output logic        dmem_cycle_complete,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_be,
    input  logic        mem_ack,
    output logic        bus_error
);

    localparam int              c_TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TW-1:0] c_TLIM = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;

    arb_state_t      r_state, w_next;
    logic            r_pend, r_pwe;
    logic [1:0]      r_pwidth;
    logic [63:0]     r_paddr, r_pdata, r_iaddr;
    logic            r_tie_seen, r_last_d;
    logic [c_TW-1:0] r_tcnt;

    logic            w_strobe, w_dreq, w_pick_i, w_grant_i, w_grant_d, w_ack, w_tout;
    logic            w_slot_we;
    logic [1:0]      w_slot_width;
    logic [63:0]     w_slot_addr, w_slot_data, w_wdata;
    logic [7:0]      w_be;

    // A fresh strobe in IDLE bypasses the pending slot so mem_req can rise next cycle.
    assign w_strobe     = (dmem_rstrobe | dmem_wstrobe) & ~r_pend & (r_state != S_DBUS);
    assign w_slot_addr  = r_pend ? r_paddr  : dmem_addr;
    assign w_slot_data  = r_pend ? r_pdata  : dmem_dout;
    assign w_slot_width = r_pend ? r_pwidth : dmem_write_width;
    assign w_slot_we    = r_pend ? r_pwe    : dmem_wstrobe;

    mem_lane_gen u_lane_gen (
        .i_width  (w_slot_width),
        .i_offset (w_slot_addr[2:0]),
        .i_data   (w_slot_data),
        .o_be     (w_be),
        .o_wdata  (w_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_dreq    = r_pend | w_strobe;
        w_pick_i  = 1'b0;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_ack     = 1'b0;
        w_tout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dreq && imem_addr_valid)
                    w_pick_i = r_tie_seen ? r_last_d : IFETCH_PRI;
                else
                    w_pick_i = imem_addr_valid;
                w_grant_i = w_pick_i;
                w_grant_d = w_dreq & ~w_pick_i;
                if (w_grant_i)      w_next = S_IBUS;
                else if (w_grant_d) w_next = S_DBUS;
            end
            S_IBUS, S_DBUS: begin
                w_ack  = mem_ack;
                w_tout = ~mem_ack && (TIMEOUT > 0) && (r_tcnt == c_TLIM);
                if (w_ack || w_tout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend              <= 1'b0;
            r_pwe               <= 1'b0;
            r_pwidth            <= 2'd0;
            r_paddr             <= '0;
            r_pdata             <= '0;
            r_iaddr             <= '0;
            r_tie_seen          <= 1'b0;
            r_last_d            <= 1'b0;
            r_tcnt              <= '0;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_be              <= 8'h00;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            imem_data           <= '0;
            imem_data_valid     <= 1'b0;
            dmem_din            <= '0;
            dmem_cycle_complete <= 1'b0;
            bus_error           <= 1'b0;
        end else begin
            imem_data_valid     <= 1'b0;
            dmem_cycle_complete <= 1'b0;
            bus_error           <= 1'b0;

            if (w_grant_d) begin
                r_pend <= 1'b0;
            end else if (w_strobe) begin
                r_pend   <= 1'b1;
                r_paddr  <= dmem_addr;
                r_pdata  <= dmem_dout;
                r_pwidth <= dmem_write_width;
                r_pwe    <= dmem_wstrobe;
            end

            if (mem_req) r_tcnt <= r_tcnt + 1'b1;

            if (w_grant_i || w_grant_d) begin
                r_tie_seen <= r_tie_seen | (w_dreq & imem_addr_valid);
                r_last_d   <= w_grant_d;
                r_tcnt     <= '0;
                r_iaddr    <= imem_addr;
                mem_req    <= 1'b1;
                mem_addr   <= {(w_grant_d ? w_slot_addr[63:3] : imem_addr[63:3]), 3'b000};
                mem_we     <= w_grant_d & w_slot_we;
                mem_be     <= (w_grant_d && w_slot_we) ? w_be : 8'hFF;
                mem_wdata  <= (w_grant_d && w_slot_we) ? w_wdata : '0;
            end

            // A timeout completes like an ack carrying all-zero data.
            if (w_ack || w_tout) begin
                mem_req   <= 1'b0;
                bus_error <= w_tout;
                if (r_state == S_DBUS) begin
                    dmem_cycle_complete <= 1'b1;
                    if (!mem_we) dmem_din <= w_ack ? mem_rdata : '0;
                end else begin
                    imem_data       <= w_ack ? mem_rdata : '0;
                    imem_data_valid <= w_ack & imem_addr_valid & (imem_addr == r_iaddr);
                end
            end
        end
    end

endmodule
`default_nettype wire
